config_launcher: RTL and testbench

Initiator side of the start/done handshake used by the parameterised feature blocks. It accepts one request at a time and issues a single-cycle `start` pulse to a downstream responder. It then waits for the responder's `done` under a cycle-count timeout, with optional relaunch after a timeout. It sits between a sequencer or test controller and one responder instance, and returns a status response for every request.

---
 rtl/config_launcher.sv | 130 +++++++++++++
 tb/tb_config_launcher.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/config_launcher.sv
// ---------------------------------------------------------------------------
// config_launcher
//   Initiator side of the start/done handshake. It accepts one request at a
//   time and fires a one-cycle start pulse at the responder. It then waits for
//   done under a cycle-count timeout and returns a status response.
//
//   Optional feature macro: CONFIG_LAUNCHER_RETRY_EN
//     defined   - a timed-out attempt is relaunched up to MAX_RETRIES times
//     undefined - the first timeout is final; rsp_retries is tied to 0
//
//   Parameters: TIMEOUT (WAIT cycles per attempt, >=1), MAX_RETRIES (>=0)
//   Ports:
//     clk, rst_n           clock, async active-low reset
//     req_valid/req_ready  request handshake (accepted only in IDLE)
//     start                one-cycle launch pulse to the responder
//     done                 completion from the responder (only seen in WAIT)
//     rsp_valid/rsp_ready  response handshake
//     rsp_timeout          final attempt timed out
//     rsp_retries          relaunches performed (saturating)
//     rsp_cycles           WAIT cycles of the final attempt
//     busy                 state is not IDLE
//   Every output is a flop, so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module config_launcher #(
    parameter int TIMEOUT     = 1000,
    parameter int MAX_RETRIES = 2,
    localparam int CW         = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    output logic          start,
    input  logic          done,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_timeout,
    output logic [7:0]    rsp_retries,
    output logic [CW-1:0] rsp_cycles,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

`ifdef CONFIG_LAUNCHER_RETRY_EN
    logic [7:0] retries;
    assign rsp_retries = retries;
`else
    assign rsp_retries = 8'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            start       <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_cycles  <= '0;
            busy        <= 1'b0;
            cnt         <= '0;
`ifdef CONFIG_LAUNCHER_RETRY_EN
            retries     <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= START;
                        start     <= 1'b1;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
`ifdef CONFIG_LAUNCHER_RETRY_EN
                        retries   <= 8'd0;
`endif
                    end
                end
                START: begin
                    // done is deliberately not looked at here
                    start <= 1'b0;
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        // done beats a timeout landing in the same cycle
                        rsp_cycles  <= cnt + CW'(1);
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
`ifdef CONFIG_LAUNCHER_RETRY_EN
                        if (32'(retries) < 32'(MAX_RETRIES)) begin
                            if (retries != 8'hFF)
                                retries <= retries + 8'd1;
                            start <= 1'b1;
                            state <= START;
                        end else begin
                            rsp_cycles  <= CW'(TIMEOUT);
                            rsp_timeout <= 1'b1;
                            rsp_valid   <= 1'b1;
                            state       <= RESP;
                        end
`else
                        rsp_cycles  <= CW'(TIMEOUT);
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_config_launcher.sv
// ---------------------------------------------------------------------------
// tb_config_launcher
//   Directed bench for config_launcher with TIMEOUT=4, MAX_RETRIES=2.
//   Expected values are worked out by hand from the handshake timing. The
//   timeout scenario follows CONFIG_LAUNCHER_RETRY_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_config_launcher;

    localparam int TO = 4;
    localparam int MR = 2;
    localparam int CW = $clog2(TO + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          start;
    logic          done = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_timeout;
    logic [7:0]    rsp_retries;
    logic [CW-1:0] rsp_cycles;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cnt = 0;
    int last_start = 0;
    int start_gap = 0;

    config_launcher #(.TIMEOUT(TO), .MAX_RETRIES(MR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .start(start), .done(done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_timeout(rsp_timeout), .rsp_retries(rsp_retries),
        .rsp_cycles(rsp_cycles), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count start pulses and the spacing between them, sampled mid-cycle.
    always @(negedge clk) begin
        if (start) begin
            start_gap  = cyc - last_start;
            last_start = cyc;
            start_cnt  = start_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a request, then raise done during WAIT cycle n and let it land.
    task automatic launch_done(input int n);
        req_valid = 1'b1;
        tick();                 // accepted, now in START
        req_valid = 1'b0;
        tick();                 // WAIT cycle 1
        repeat (n - 1) tick();  // WAIT cycle n
        done = 1'b1;
        tick();                 // RESP
        done = 1'b0;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    int s0;
    int k;
    int unstable;

    initial begin
        // 1. reset and idle
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_cycles", 32'(rsp_cycles), 0);
        chk("rst_rsp_retries", 32'(rsp_retries), 0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 0);

        // 2. normal completion, done in WAIT cycle 3
        s0 = start_cnt;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("n_start_c1", 32'(start), 1);
        chk("n_busy", 32'(busy), 1);
        chk("n_req_ready", 32'(req_ready), 0);
        tick();
        chk("n_start_c2", 32'(start), 0);
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("n_rsp_valid", 32'(rsp_valid), 1);
        chk("n_timeout", 32'(rsp_timeout), 0);
        chk("n_cycles", 32'(rsp_cycles), 3);
        chk("n_retries", 32'(rsp_retries), 0);
        chk("n_start_cnt", 32'(start_cnt - s0), 1);
        release_rsp();
        chk("n_idle_ready", 32'(req_ready), 1);
        chk("n_idle_valid", 32'(rsp_valid), 0);

        // 3. done in the timeout cycle wins
        launch_done(4);
        chk("b_rsp_valid", 32'(rsp_valid), 1);
        chk("b_timeout", 32'(rsp_timeout), 0);
        chk("b_cycles", 32'(rsp_cycles), 4);
        release_rsp();

        // 4. no done at all
        s0 = start_cnt;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 60) begin
            tick();
            k++;
        end
        chk("t_timeout", 32'(rsp_timeout), 1);
        chk("t_cycles", 32'(rsp_cycles), 4);
`ifdef CONFIG_LAUNCHER_RETRY_EN
        chk("t_latency", 32'(k), 15);
        chk("t_starts", 32'(start_cnt - s0), 3);
        chk("t_gap", 32'(start_gap), 5);
        chk("t_retries", 32'(rsp_retries), 2);
`else
        chk("t_latency", 32'(k), 5);
        chk("t_starts", 32'(start_cnt - s0), 1);
        chk("t_retries", 32'(rsp_retries), 0);
`endif

        // 1b. reset dropped mid-cycle in RESP clears outputs immediately
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rsp_valid", 32'(rsp_valid), 0);
        chk("ar_timeout", 32'(rsp_timeout), 0);
        chk("ar_cycles", 32'(rsp_cycles), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_retries", 32'(rsp_retries), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 5. backpressure with a stray done and a pending request
        launch_done(2);
        s0 = start_cnt;
        unstable = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            done = (i == 3);
            tick();
            if (!rsp_valid || rsp_cycles != CW'(2) || rsp_timeout || req_ready || start)
                unstable++;
        end
        done = 1'b0;
        req_valid = 1'b0;
        chk("bp_unstable", 32'(unstable), 0);
        chk("bp_cycles", 32'(rsp_cycles), 2);
        chk("bp_req_ready", 32'(req_ready), 0);
        release_rsp();
        chk("bp_ready_after", 32'(req_ready), 1);
        chk("bp_valid_after", 32'(rsp_valid), 0);
        chk("bp_no_start", 32'(start_cnt - s0), 0);

        // 6. reset during WAIT cycle 2 aborts the transaction
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        s0 = start_cnt;
        chk("rw_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("rw_no_start", 32'(start_cnt - s0), 0);
        chk("rw_no_rsp", 32'(rsp_valid), 0);
        chk("rw_req_ready", 32'(req_ready), 1);
        s0 = start_cnt;
        launch_done(3);
        chk("rw_rsp_valid", 32'(rsp_valid), 1);
        chk("rw_cycles", 32'(rsp_cycles), 3);
        chk("rw_timeout", 32'(rsp_timeout), 0);
        chk("rw_starts", 32'(start_cnt - s0), 1);
        release_rsp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
